// File: rtl/mem_bus_bridge_pkg.sv
// Shared types and constants for the MEM-stage data bus bridge.
package mem_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_DONE,
        ST_DRAIN
    } bridge_state_t;

    localparam logic [6:0] DEFAULT_ALE_CODE    = 7'h09;
    localparam logic [6:0] DEFAULT_BUSERR_CODE = 7'h08;
    localparam logic [1:0] BUS_RESP_OKAY       = 2'b00;

endpackage

// File: rtl/mem_bus_bridge_if.sv
// Single-beat data bus: read address/data channels plus a combined
// write address+data channel with a write response channel.
interface mem_bus_bridge_if;

    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;

    modport master (
        output arvalid, araddr, rready, awvalid, awaddr, wdata, wstrb, bready,
        input  arready, rvalid, rdata, rresp, awready, bvalid, bresp
    );

    modport slave (
        input  arvalid, araddr, rready, awvalid, awaddr, wdata, wstrb, bready,
        output arready, rvalid, rdata, rresp, awready, bvalid, bresp
    );

endinterface

// File: rtl/mem_bus_bridge_align_check.sv
// Misaligned-access detector for word and halfword requests.
module mem_align_check (
    input  logic       i_en,
    input  logic       i_word,
    input  logic       i_halfword,
    input  logic [1:0] i_addr_lo,
    output logic       o_mis
);

    // Word needs addr[1:0]==0, halfword needs addr[0]==0; bytes never fault.
    always_comb begin
        o_mis = i_en & ((i_word & (i_addr_lo != 2'b00)) | (i_halfword & i_addr_lo[0]));
    end

endmodule

// File: rtl/mem_bus_bridge.sv
// MEM-stage data bus bridge: turns a level-held SRAM-style request into one
// single-beat valid/ready transaction and holds the result until MEM fires.
// Optional build macro BUS_ERR_EXCP_EN: a nonzero bus response raises an
// exception (BUSERR_CODE) alongside the completion flag in DONE.
module mem_bus_bridge
    import mem_bus_pkg::*;
#(
    parameter logic [6:0] ALE_CODE    = DEFAULT_ALE_CODE,
    parameter logic [6:0] BUSERR_CODE = DEFAULT_BUSERR_CODE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req_en,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wmask,
    input  logic              req_word,
    input  logic              req_halfword,
    input  logic              stage_fire,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_rdata_valid,
    output logic              rsp_write_finish,
    output logic              rsp_excp,
    output logic [6:0]        rsp_excp_num,
    mem_bus_bridge_if.master  bus
);

    bridge_state_t r_state;
    bridge_state_t w_next_state;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wmask;
    logic [31:0] r_rdata;
    logic        r_is_store;
    // Set in DRAIN while the address-phase handshake is still outstanding.
    logic        r_pend_addr;
`ifdef BUS_ERR_EXCP_EN
    logic [1:0]  r_resp;
`endif

    logic w_mis;
    logic w_accept;
    logic w_abort;
    logic w_bus_err;

    mem_align_check u_align (
        .i_en       (req_en),
        .i_word     (req_word),
        .i_halfword (req_halfword),
        .i_addr_lo  (req_addr[1:0]),
        .o_mis      (w_mis)
    );

    assign w_accept = req_en & ~w_mis & ~flush;
    assign w_abort  = flush | ~req_en;

`ifdef BUS_ERR_EXCP_EN
    assign w_bus_err = (r_state == ST_DONE) && (r_resp != BUS_RESP_OKAY);
`else
    assign w_bus_err = 1'b0;
`endif

    // State register and request/response capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wmask     <= '0;
            r_rdata     <= '0;
            r_is_store  <= 1'b0;
            r_pend_addr <= 1'b0;
`ifdef BUS_ERR_EXCP_EN
            r_resp      <= '0;
`endif
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr      <= {req_addr[31:2], 2'b00};
                        r_wdata     <= req_wdata;
                        r_wmask     <= req_wmask;
                        r_is_store  <= req_we;
                        r_pend_addr <= 1'b0;
                    end
                end
                ST_RD_ADDR: begin
                    if (w_abort) r_pend_addr <= ~bus.arready;
                end
                ST_RD_DATA: begin
                    if (bus.rvalid & ~w_abort) begin
                        r_rdata <= bus.rdata;
`ifdef BUS_ERR_EXCP_EN
                        r_resp  <= bus.rresp;
`endif
                    end
                end
                ST_WR_REQ: begin
                    if (w_abort) r_pend_addr <= ~bus.awready;
                end
                ST_WR_RESP: begin
`ifdef BUS_ERR_EXCP_EN
                    if (bus.bvalid & ~w_abort) r_resp <= bus.bresp;
`endif
                end
                ST_DRAIN: begin
                    if (r_pend_addr & (r_is_store ? bus.awready : bus.arready))
                        r_pend_addr <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Next-state decode and bus/response outputs.
    always_comb begin
        w_next_state     = r_state;
        bus.arvalid      = 1'b0;
        bus.rready       = 1'b0;
        bus.awvalid      = 1'b0;
        bus.bready       = 1'b0;
        bus.araddr       = r_addr;
        bus.awaddr       = r_addr;
        bus.wdata        = r_wdata;
        bus.wstrb        = r_wmask;
        rsp_rdata_valid  = 1'b0;
        rsp_write_finish = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next_state = req_we ? ST_WR_REQ : ST_RD_ADDR;
            end
            ST_RD_ADDR: begin
                bus.arvalid = 1'b1;
                if (w_abort)          w_next_state = ST_DRAIN;
                else if (bus.arready) w_next_state = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                bus.rready = 1'b1;
                if (bus.rvalid)   w_next_state = w_abort ? ST_IDLE : ST_DONE;
                else if (w_abort) w_next_state = ST_DRAIN;
            end
            ST_WR_REQ: begin
                bus.awvalid = 1'b1;
                if (w_abort)          w_next_state = ST_DRAIN;
                else if (bus.awready) w_next_state = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                bus.bready = 1'b1;
                if (bus.bvalid)   w_next_state = w_abort ? ST_IDLE : ST_DONE;
                else if (w_abort) w_next_state = ST_DRAIN;
            end
            ST_DONE: begin
                rsp_rdata_valid  = ~r_is_store;
                rsp_write_finish = r_is_store;
                if (flush | stage_fire) w_next_state = ST_IDLE;
            end
            ST_DRAIN: begin
                // One state covers both phases of an abandoned transfer:
                // finish the address handshake, then swallow the response.
                if (r_pend_addr) begin
                    bus.arvalid = ~r_is_store;
                    bus.awvalid = r_is_store;
                end else if (r_is_store) begin
                    bus.bready = 1'b1;
                    if (bus.bvalid) w_next_state = ST_IDLE;
                end else begin
                    bus.rready = 1'b1;
                    if (bus.rvalid) w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Exception reporting: misalignment takes priority over a bus error.
    always_comb begin
        rsp_excp     = w_mis | w_bus_err;
        rsp_excp_num = w_mis ? ALE_CODE : (w_bus_err ? BUSERR_CODE : '0);
    end

    assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Scoreboard bench for mem_bus_bridge with a delay-configurable bus slave.
module tb_mem_bus_bridge;

`ifdef BUS_ERR_EXCP_EN
    localparam bit EXP_BE = 1'b1;
`else
    localparam bit EXP_BE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        req_en;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        req_word;
    logic        req_halfword;
    logic        stage_fire;
    logic [31:0] rsp_rdata;
    logic        rsp_rdata_valid;
    logic        rsp_write_finish;
    logic        rsp_excp;
    logic [6:0]  rsp_excp_num;

    mem_bus_bridge_if bus_if();

    mem_bus_bridge dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .req_en           (req_en),
        .req_we           (req_we),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_wmask        (req_wmask),
        .req_word         (req_word),
        .req_halfword     (req_halfword),
        .stage_fire       (stage_fire),
        .rsp_rdata        (rsp_rdata),
        .rsp_rdata_valid  (rsp_rdata_valid),
        .rsp_write_finish (rsp_write_finish),
        .rsp_excp         (rsp_excp),
        .rsp_excp_num     (rsp_excp_num),
        .bus              (bus_if)
    );

    always #5 clk = ~clk;

    // ---------------- bus slave model ----------------
    int          ar_delay = 0, r_delay = 0, aw_delay = 0, b_delay = 0;
    int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, b_cnt = 0;
    logic        rd_pend = 1'b0, wr_pend = 1'b0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  s_rresp = '0, s_bresp = '0;

    assign bus_if.arready = bus_if.arvalid && (ar_cnt >= ar_delay);
    assign bus_if.rvalid  = rd_pend && (r_cnt >= r_delay);
    assign bus_if.rdata   = s_rdata;
    assign bus_if.rresp   = s_rresp;
    assign bus_if.awready = bus_if.awvalid && (aw_cnt >= aw_delay);
    assign bus_if.bvalid  = wr_pend && (b_cnt >= b_delay);
    assign bus_if.bresp   = s_bresp;

    initial begin
        int   n_ar, n_rc, n_aw, n_bc;
        logic n_rp, n_wp;
        forever begin
            @(negedge clk);
            n_ar = (bus_if.arvalid && !bus_if.arready) ? ar_cnt + 1 : 0;
            n_aw = (bus_if.awvalid && !bus_if.awready) ? aw_cnt + 1 : 0;
            n_rp = rd_pend; n_rc = r_cnt;
            n_wp = wr_pend; n_bc = b_cnt;
            if (rd_pend && bus_if.rvalid && bus_if.rready) n_rp = 1'b0;
            else if (rd_pend && !bus_if.rvalid)           n_rc = r_cnt + 1;
            if (bus_if.arvalid && bus_if.arready) begin n_rp = 1'b1; n_rc = 0; end
            if (wr_pend && bus_if.bvalid && bus_if.bready) n_wp = 1'b0;
            else if (wr_pend && !bus_if.bvalid)           n_bc = b_cnt + 1;
            if (bus_if.awvalid && bus_if.awready) begin n_wp = 1'b1; n_bc = 0; end
            if (reset) begin
                n_ar = 0; n_aw = 0; n_rc = 0; n_bc = 0; n_rp = 1'b0; n_wp = 1'b0;
            end
            @(posedge clk); #1;
            ar_cnt = n_ar; aw_cnt = n_aw; r_cnt = n_rc; b_cnt = n_bc;
            rd_pend = n_rp; wr_pend = n_wp;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        rv;
        logic        wf;
        logic        ex;
        logic [6:0]  num;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Monitor: compare every presented response against the queue head,
    // retire the entry when MEM fires.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && (rsp_rdata_valid || rsp_write_finish || rsp_excp)) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: got rv=%b wf=%b ex=%b want no response",
                             rsp_rdata_valid, rsp_write_finish, rsp_excp);
                end else begin
                    e = sbq[0];
                    chk("sb_rdata_valid", rsp_rdata_valid, e.rv);
                    chk("sb_write_finish", rsp_write_finish, e.wf);
                    chk("sb_excp", rsp_excp, e.ex);
                    if (e.ex) chk("sb_excp_num", rsp_excp_num, e.num);
                    if (e.rv) chk("sb_rdata", rsp_rdata, e.data);
                    if (stage_fire) void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        bit seen;
        int aw_cycles;

        reset = 1'b1; flush = 1'b0; req_en = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_wmask = '0;
        req_word = 1'b0; req_halfword = 1'b0; stage_fire = 1'b0;
        repeat (3) tick();
        at_neg();
        chk("rst_arvalid", bus_if.arvalid, 0);
        chk("rst_awvalid", bus_if.awvalid, 0);
        chk("rst_rready", bus_if.rready, 0);
        chk("rst_bready", bus_if.bready, 0);
        chk("rst_rdata_valid", rsp_rdata_valid, 0);
        chk("rst_write_finish", rsp_write_finish, 0);
        chk("rst_excp", rsp_excp, 0);
        chk("rst_rdata", rsp_rdata, 0);
        tick();
        reset = 1'b0;

        // Word load, zero-wait slave.
        s_rdata = 32'hDEADBEEF;
        req_en = 1'b1; req_we = 1'b0; req_addr = 32'h1C000104; req_word = 1'b1;
        sbq.push_back('{1'b1, 1'b0, 1'b0, 7'h00, 32'hDEADBEEF});
        at_neg(); chk("t1_T0_arvalid", bus_if.arvalid, 0);
        tick(); at_neg();
        chk("t1_T1_arvalid", bus_if.arvalid, 1);
        chk("t1_T1_araddr", bus_if.araddr, 32'h1C000104);
        tick(); at_neg();
        chk("t1_T2_rready", bus_if.rready, 1);
        chk("t1_T2_rdata_valid", rsp_rdata_valid, 0);
        tick(); at_neg();
        chk("t1_T3_rdata_valid", rsp_rdata_valid, 1);
        chk("t1_T3_rdata", rsp_rdata, 32'hDEADBEEF);
        tick(); at_neg();
        chk("t1_T4_hold", rsp_rdata_valid, 1);
        tick(); stage_fire = 1'b1; at_neg();
        tick(); stage_fire = 1'b0; req_en = 1'b0; at_neg();
        chk("t1_after_fire", rsp_rdata_valid, 0);
        tick();

        // Byte store with awready delayed 3 cycles.
        aw_delay = 3;
        req_en = 1'b1; req_we = 1'b1; req_addr = 32'h1C000203; req_word = 1'b0;
        req_halfword = 1'b0; req_wmask = 4'b1000; req_wdata = 32'h5A000000;
        sbq.push_back('{1'b0, 1'b1, 1'b0, 7'h00, 32'h0});
        seen = 1'b0; aw_cycles = 0;
        for (int n = 0; n < 20; n++) begin
            at_neg();
            if (bus_if.awvalid) begin
                aw_cycles++;
                chk("t2_awaddr", bus_if.awaddr, 32'h1C000200);
                chk("t2_wstrb", bus_if.wstrb, 4'b1000);
                chk("t2_wdata", bus_if.wdata, 32'h5A000000);
            end
            if (bus_if.bvalid) begin
                chk("t2_bready", bus_if.bready, 1);
                chk("t2_wf_during_b", rsp_write_finish, 0);
                tick(); at_neg();
                chk("t2_wf_after_b", rsp_write_finish, 1);
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("t2_bvalid_seen", seen, 1);
        chk("t2_aw_cycles", aw_cycles, 4);
        tick(); stage_fire = 1'b1; at_neg();
        tick(); stage_fire = 1'b0; req_en = 1'b0; req_we = 1'b0; aw_delay = 0;
        at_neg(); tick();

        // Misaligned halfword load: immediate exception, no bus activity.
        req_en = 1'b1; req_we = 1'b0; req_addr = 32'h1C000001; req_halfword = 1'b1;
        stage_fire = 1'b1;
        sbq.push_back('{1'b0, 1'b0, 1'b1, 7'h09, 32'h0});
        at_neg();
        chk("t3_excp", rsp_excp, 1);
        chk("t3_excp_num", rsp_excp_num, 7'h09);
        chk("t3_arvalid_T0", bus_if.arvalid, 0);
        tick(); stage_fire = 1'b0; req_en = 1'b0; req_halfword = 1'b0;
        for (int n = 0; n < 3; n++) begin
            at_neg();
            chk("t3_no_arvalid", bus_if.arvalid, 0);
            tick();
        end

        // Flush in RD_DATA, rvalid four cycles late: drain and discard.
        r_delay = 4; s_rdata = 32'hCAFEF00D;
        req_en = 1'b1; req_we = 1'b0; req_addr = 32'h00000040; req_word = 1'b1;
        at_neg(); tick(); at_neg();
        chk("t4_arvalid", bus_if.arvalid, 1);
        tick(); flush = 1'b1; at_neg();
        chk("t4_rready_flush", bus_if.rready, 1);
        tick(); flush = 1'b0; req_en = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            at_neg();
            chk("t4_rready_held", bus_if.rready, 1);
            if (bus_if.rvalid) begin
                seen = 1'b1;
                tick();
                break;
            end
            tick();
        end
        chk("t4_rvalid_seen", seen, 1);
        at_neg();
        chk("t4_idle_rready", bus_if.rready, 0);
        chk("t4_idle_arvalid", bus_if.arvalid, 0);
        chk("t4_no_rdata_valid", rsp_rdata_valid, 0);
        tick();

        // stage_fire delayed 5 cycles, then back-to-back store.
        r_delay = 0; s_rdata = 32'h12345678;
        req_en = 1'b1; req_we = 1'b0; req_addr = 32'h00000100; req_word = 1'b1;
        sbq.push_back('{1'b1, 1'b0, 1'b0, 7'h00, 32'h12345678});
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            at_neg();
            if (rsp_rdata_valid) begin seen = 1'b1; break; end
            tick();
        end
        chk("t5_rdata_valid_seen", seen, 1);
        for (int k = 0; k < 5; k++) begin
            chk("t5_hold_valid", rsp_rdata_valid, 1);
            chk("t5_hold_rdata", rsp_rdata, 32'h12345678);
            tick();
            if (k != 4) at_neg();
        end
        stage_fire = 1'b1; at_neg();
        tick();
        stage_fire = 1'b0; req_we = 1'b1; req_addr = 32'h00000200;
        req_wdata = 32'hA5A5A5A5; req_wmask = 4'b1111;
        sbq.push_back('{1'b0, 1'b1, 1'b0, 7'h00, 32'h0});
        at_neg();
        chk("t5_idle_awvalid", bus_if.awvalid, 0);
        tick(); at_neg();
        chk("t5_b2b_awvalid", bus_if.awvalid, 1);
        chk("t5_b2b_awaddr", bus_if.awaddr, 32'h00000200);
        chk("t5_b2b_wdata", bus_if.wdata, 32'hA5A5A5A5);
        tick(); at_neg();
        chk("t5_bvalid", bus_if.bvalid, 1);
        tick(); at_neg();
        chk("t5_write_finish", rsp_write_finish, 1);
        tick(); stage_fire = 1'b1; at_neg();
        tick(); stage_fire = 1'b0; req_en = 1'b0; req_we = 1'b0;
        at_neg(); tick();

        // Store with bresp=SLVERR.
        s_bresp = 2'b10;
        req_en = 1'b1; req_we = 1'b1; req_addr = 32'h00000300; req_word = 1'b1;
        req_wmask = 4'b1111; req_wdata = 32'h0BADF00D;
        sbq.push_back('{1'b0, 1'b1, EXP_BE, EXP_BE ? 7'h08 : 7'h00, 32'h0});
        at_neg(); tick(); at_neg(); tick(); at_neg(); tick();
        stage_fire = 1'b1; at_neg();
        chk("t6_write_finish", rsp_write_finish, 1);
        chk("t6_excp", rsp_excp, EXP_BE);
        if (EXP_BE) chk("t6_excp_num", rsp_excp_num, 7'h08);
        tick(); stage_fire = 1'b0; req_en = 1'b0; req_we = 1'b0; s_bresp = 2'b00;

        repeat (3) tick();
        chk("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
